// File: rtl/rvfi_reorder_buffer.sv
// Reorder buffer for one RVFI retirement channel: collects records tagged with
// rvfi_order in any order and re-emits them strictly ascending, one per cycle.
module rvfi_reorder_buffer #(
  parameter int XLEN    = 32,
  parameter int ORDER_W = 8,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [ORDER_W-1:0]       in_order,
  input  logic [31:0]              in_insn,
  input  logic [XLEN-1:0]          in_pre_pc,
  input  logic [XLEN-1:0]          in_post_pc,
  input  logic                     in_trap,
  output logic                     out_valid,
  output logic [ORDER_W-1:0]       out_order,
  output logic [31:0]              out_insn,
  output logic [XLEN-1:0]          out_pre_pc,
  output logic [XLEN-1:0]          out_post_pc,
  output logic                     out_trap,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_dup,
  output logic                     err_window
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [ORDER_W-1:0] DEPTH_O = ORDER_W'(DEPTH);

  logic [ORDER_W-1:0] r_next_order;
  logic [DEPTH-1:0]   r_slot_valid;
  logic [OCC_W-1:0]   r_occupancy;
  logic               r_err_dup;
  logic               r_err_window;

  logic [31:0]        r_insn_mem    [DEPTH];
  logic [XLEN-1:0]    r_pre_pc_mem  [DEPTH];
  logic [XLEN-1:0]    r_post_pc_mem [DEPTH];
  logic               r_trap_mem    [DEPTH];

  logic               r_out_valid;
  logic [ORDER_W-1:0] r_out_order;
  logic [31:0]        r_out_insn;
  logic [XLEN-1:0]    r_out_pre_pc;
  logic [XLEN-1:0]    r_out_post_pc;
  logic               r_out_trap;

  logic [ORDER_W-1:0] w_diff;
  logic [IDX_W-1:0]   w_in_idx;
  logic [IDX_W-1:0]   w_head_idx;
  logic               w_in_window;
  logic               w_stale;
  logic               w_accept;
  logic               w_dup;
  logic               w_far;
  logic               w_drain;

  // Distance ahead of the next expected order; the top half of the modular
  // range means the order has already been emitted.
  assign w_diff      = in_order - r_next_order;
  assign w_in_idx    = in_order[IDX_W-1:0];
  assign w_head_idx  = r_next_order[IDX_W-1:0];
  assign w_in_window = (w_diff < DEPTH_O);
  assign w_stale     = w_diff[ORDER_W-1];

  assign w_accept = in_valid && w_in_window && !r_slot_valid[w_in_idx];
  assign w_dup    = in_valid && ((w_in_window && r_slot_valid[w_in_idx]) || w_stale);
  assign w_far    = in_valid && !w_in_window && !w_stale;
  assign w_drain  = r_slot_valid[w_head_idx];

  // NOTE: state registers use non-blocking assignments so every block sees the
  // pre-edge values, which is what lets accept and drain share an edge safely.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_next_order  <= '0;
      r_slot_valid  <= '0;
      r_occupancy   <= '0;
      r_err_dup     <= 1'b0;
      r_err_window  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_order   <= '0;
      r_out_insn    <= '0;
      r_out_pre_pc  <= '0;
      r_out_post_pc <= '0;
      r_out_trap    <= 1'b0;
    end else begin
      r_out_valid <= w_drain;
      if (w_drain) begin
        r_slot_valid[w_head_idx] <= 1'b0;
        r_next_order  <= r_next_order + 1'b1;
        r_out_order   <= r_next_order;
        r_out_insn    <= r_insn_mem[w_head_idx];
        r_out_pre_pc  <= r_pre_pc_mem[w_head_idx];
        r_out_post_pc <= r_post_pc_mem[w_head_idx];
        r_out_trap    <= r_trap_mem[w_head_idx];
      end
      // An accepted record never targets the head slot while it drains:
      // diff==0 can only be accepted when that slot is empty.
      if (w_accept) begin
        r_slot_valid[w_in_idx] <= 1'b1;
      end
      r_occupancy <= r_occupancy + OCC_W'(w_accept) - OCC_W'(w_drain);
      if (w_dup) begin
        r_err_dup <= 1'b1;
      end
      if (w_far) begin
        r_err_window <= 1'b1;
      end
    end
  end

  // NOTE: the payload memory has no reset; slot contents are only observed
  // behind a set valid bit, so clearing them would add logic for nothing.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_insn_mem[w_in_idx]    <= in_insn;
      r_pre_pc_mem[w_in_idx]  <= in_pre_pc;
      r_post_pc_mem[w_in_idx] <= in_post_pc;
      r_trap_mem[w_in_idx]    <= in_trap;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_order   = r_out_order;
  assign out_insn    = r_out_insn;
  assign out_pre_pc  = r_out_pre_pc;
  assign out_post_pc = r_out_post_pc;
  assign out_trap    = r_out_trap;
  assign occupancy   = r_occupancy;
  assign err_dup     = r_err_dup;
  assign err_window  = r_err_window;

endmodule

// File: tb/tb_rvfi_reorder_buffer.sv
// Scoreboard bench for rvfi_reorder_buffer: expected records are queued in
// emission order as stimulus is driven and compared as the DUT emits them.
module tb_rvfi_reorder_buffer;

  typedef struct packed {
    logic [7:0]  order;
    logic [31:0] insn;
    logic [31:0] pre_pc;
    logic [31:0] post_pc;
    logic        trap;
  } rec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_order = '0;
  logic [31:0] in_insn = '0;
  logic [31:0] in_pre_pc = '0;
  logic [31:0] in_post_pc = '0;
  logic        in_trap = 1'b0;
  logic        out_valid;
  logic [7:0]  out_order;
  logic [31:0] out_insn;
  logic [31:0] out_pre_pc;
  logic [31:0] out_post_pc;
  logic        out_trap;
  logic [3:0]  occupancy;
  logic        err_dup;
  logic        err_window;

  rec_t exp_q[$];
  rec_t mon_rec;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   emit_cnt = 0;
  int   first_emit_cyc = 0;
  int   last_emit_cyc = 0;
  int   c0;

  rvfi_reorder_buffer #(.XLEN(32), .ORDER_W(8), .DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn),
    .in_pre_pc(in_pre_pc), .in_post_pc(in_post_pc), .in_trap(in_trap),
    .out_valid(out_valid), .out_order(out_order), .out_insn(out_insn),
    .out_pre_pc(out_pre_pc), .out_post_pc(out_post_pc), .out_trap(out_trap),
    .occupancy(occupancy), .err_dup(err_dup), .err_window(err_window)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t mk(input int ord, input int salt);
    rec_t r;
    r.order   = 8'(ord);
    r.insn    = {8'(salt), 16'h1357, 8'(ord)};
    r.pre_pc  = 32'h1000_0000 + 32'(salt << 20) + 32'(ord * 4);
    r.post_pc = r.pre_pc + 32'd4 + 32'(salt);
    r.trap    = ord[0] ^ salt[0];
    return r;
  endfunction

  // Every send starts one time unit after a rising edge and is accepted at the next one.
  task automatic send(input rec_t r);
    in_valid   = 1'b1;
    in_order   = r.order;
    in_insn    = r.insn;
    in_pre_pc  = r.pre_pc;
    in_post_pc = r.post_pc;
    in_trap    = r.trap;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    emit_cnt = 0;
    first_emit_cyc = 0;
    last_emit_cyc = 0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_emit", 64'(out_order), 64'hFFFF_FFFF);
      end else begin
        mon_rec = exp_q.pop_front();
        check("out_order",   64'(out_order),   64'(mon_rec.order));
        check("out_insn",    64'(out_insn),    64'(mon_rec.insn));
        check("out_pre_pc",  64'(out_pre_pc),  64'(mon_rec.pre_pc));
        check("out_post_pc", 64'(out_post_pc), 64'(mon_rec.post_pc));
        check("out_trap",    64'(out_trap),    64'(mon_rec.trap));
      end
      if (emit_cnt == 0) first_emit_cyc = cyc;
      last_emit_cyc = cyc;
      emit_cnt++;
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_order",  64'(out_order),  64'd0);
    check("rst_out_insn",   64'(out_insn),   64'd0);
    check("rst_occupancy",  64'(occupancy),  64'd0);
    check("rst_err_dup",    64'(err_dup),    64'd0);
    check("rst_err_window", 64'(err_window), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // In-order stream 0..15
    clear_stats();
    c0 = cyc;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(mk(k, 0));
      send(mk(k, 0));
    end
    wait_drain("inorder_drain");
    check("inorder_latency", 64'(first_emit_cyc - c0), 64'd2);
    check("inorder_contig",  64'(last_emit_cyc - first_emit_cyc), 64'd15);
    check("inorder_count",   64'(emit_cnt), 64'd16);
    check("inorder_err_dup", 64'(err_dup), 64'd0);
    check("inorder_err_win", 64'(err_window), 64'd0);

    // Reversed window 7..0 (next_order is 16 now, so use 16+7..16)
    clear_stats();
    for (int k = 16; k < 24; k++) exp_q.push_back(mk(k, 1));
    for (int k = 23; k >= 16; k--) send(mk(k, 1));
    @(negedge clk);
    check("rev_occ_peak",    64'(occupancy), 64'd8);
    check("rev_no_early",    64'(emit_cnt), 64'd0);
    wait_drain("rev_drain");
    check("rev_count",       64'(emit_cnt), 64'd8);
    check("rev_contig",      64'(last_emit_cyc - first_emit_cyc), 64'd7);
    check("rev_occ_end",     64'(occupancy), 64'd0);

    // Wrap-around at next_order=254
    do_reset();
    for (int k = 0; k < 254; k++) begin
      exp_q.push_back(mk(k, 3));
      send(mk(k, 3));
    end
    exp_q.push_back(mk(254, 2));
    exp_q.push_back(mk(255, 2));
    exp_q.push_back(mk(0, 4));
    exp_q.push_back(mk(1, 4));
    send(mk(255, 2));
    send(mk(254, 2));
    send(mk(0, 4));
    send(mk(1, 4));
    wait_drain("wrap_drain");
    check("wrap_err_dup", 64'(err_dup), 64'd0);
    check("wrap_err_win", 64'(err_window), 64'd0);
    check("wrap_occ",     64'(occupancy), 64'd0);

    // Duplicate while buffered: first copy wins, single emit
    do_reset();
    clear_stats();
    send(mk(3, 5));
    send(mk(3, 6));
    @(negedge clk);
    check("dup_err_dup", 64'(err_dup), 64'd1);
    check("dup_occ",     64'(occupancy), 64'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(k, 5));
    for (int k = 0; k < 3; k++) send(mk(k, 5));
    wait_drain("dup_drain");
    check("dup_count",   64'(emit_cnt), 64'd4);

    // Stale order after emission
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(k, 9));
      send(mk(k, 9));
    end
    wait_drain("stale_drain");
    check("stale_pre_err", 64'(err_dup), 64'd0);
    send(mk(2, 10));
    @(negedge clk);
    check("stale_err_dup", 64'(err_dup), 64'd1);
    check("stale_err_win", 64'(err_window), 64'd0);
    check("stale_occ",     64'(occupancy), 64'd0);
    @(posedge clk);
    #1;

    // Window edges: diff 7 accepted, diff 8 rejected
    do_reset();
    send(mk(7, 11));
    send(mk(8, 11));
    @(negedge clk);
    check("win_err_window", 64'(err_window), 64'd1);
    check("win_err_dup",    64'(err_dup), 64'd0);
    check("win_occ",        64'(occupancy), 64'd1);
    @(posedge clk);
    #1;

    // diff 127 is a window error, diff 128 is stale
    do_reset();
    send(mk(127, 12));
    @(negedge clk);
    check("d127_err_window", 64'(err_window), 64'd1);
    check("d127_err_dup",    64'(err_dup), 64'd0);
    @(posedge clk);
    #1;
    do_reset();
    send(mk(128, 12));
    @(negedge clk);
    check("d128_err_dup",    64'(err_dup), 64'd1);
    check("d128_err_window", 64'(err_window), 64'd0);
    check("d128_occ",        64'(occupancy), 64'd0);
    @(posedge clk);
    #1;

    // Reset mid-operation discards buffered records
    do_reset();
    exp_q.push_back(mk(0, 7));
    send(mk(0, 7));
    send(mk(9, 7));
    send(mk(2, 7));
    send(mk(3, 7));
    wait_drain("mid_pre_drain");
    check("mid_pre_occ", 64'(occupancy), 64'd2);
    check("mid_pre_win", 64'(err_window), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_out_valid",   64'(out_valid),   64'd0);
    check("mid_out_order",   64'(out_order),   64'd0);
    check("mid_out_insn",    64'(out_insn),    64'd0);
    check("mid_out_pre_pc",  64'(out_pre_pc),  64'd0);
    check("mid_out_post_pc", 64'(out_post_pc), 64'd0);
    check("mid_out_trap",    64'(out_trap),    64'd0);
    check("mid_occ",         64'(occupancy),   64'd0);
    check("mid_err_window",  64'(err_window),  64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    exp_q.push_back(mk(0, 8));
    exp_q.push_back(mk(1, 8));
    send(mk(0, 8));
    send(mk(1, 8));
    wait_drain("mid_post_drain");
    repeat (12) @(posedge clk);
    #1;
    check("mid_post_count", 64'(emit_cnt), 64'd2);
    check("mid_post_occ",   64'(occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvfi_reorder_buffer.md
Name: rvfi_reorder_buffer

Overview:
- Upstream stage of the RVFI consistency checkers, including the PC-continuity checker.
- Accepts retirement records from one RVFI channel in any retirement order.
- Buffers them by `rvfi_order` and re-emits them strictly in ascending order, one per cycle, so downstream checkers see a gap-free, in-order stream.
- Flags duplicate and out-of-window order numbers with sticky error outputs.

Parameters:
- XLEN, 32, data/PC width (matches RISCV_FORMAL_XLEN).
- ORDER_W, 8, width of the order field.
- DEPTH, 8, reorder window in entries; must be a power of 2 and ≤ 2^(ORDER_W-1).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  retirement record present this cycle.
- in_order  in  ORDER_W  instruction order number.
- in_insn  in  32  instruction word.
- in_pre_pc  in  XLEN  PC before the instruction.
- in_post_pc  in  XLEN  PC after the instruction.
- in_trap  in  1  instruction trapped.
- out_valid  out  1  in-order record valid (no backpressure).
- out_order  out  ORDER_W  order of the emitted record.
- out_insn  out  32  emitted instruction word.
- out_pre_pc  out  XLEN  emitted pre-PC.
- out_post_pc  out  XLEN  emitted post-PC.
- out_trap  out  1  emitted trap flag.
- occupancy  out  $clog2(DEPTH)+1  number of entries currently held.
- err_dup  out  1  sticky: duplicate or stale order received.
- err_window  out  1  sticky: order beyond the reorder window received.

Behaviour:
- Reset (asynchronous, resetn=0):
  - next_order=0; all slot-valid bits=0; occupancy=0.
  - out_valid=0 and all out_* fields=0.
  - err_dup=0, err_window=0.
  - Applies immediately, including mid-operation; buffered records are discarded.
- Storage:
  - DEPTH slots; slot index = in_order[log2(DEPTH)-1:0].
  - Each slot holds insn, pre_pc, post_pc, trap and a valid bit.
- Classification: diff = (in_order - next_order) mod 2^ORDER_W, compared unsigned.
  - diff < DEPTH and slot empty: accept; write slot and set its valid bit at this edge.
  - diff < DEPTH and slot valid: duplicate; set err_dup and drop the record (slot unchanged).
  - diff ≥ 2^(ORDER_W-1): stale (already emitted); set err_dup and drop.
  - DEPTH ≤ diff < 2^(ORDER_W-1): set err_window and drop.
- Drain, evaluated every edge using slot state from before the edge:
  - If slot[next_order] is valid, then at this edge:
    - load out_* from that slot, with out_order=next_order;
    - set out_valid=1;
    - clear the slot valid bit;
    - next_order++ (wraps modulo 2^ORDER_W).
  - Otherwise out_valid=0 next cycle.
- Latency: a record accepted at edge E, when it is next in order, is presented with out_valid=1 in the cycle following edge E+1. There is no same-edge bypass.
- Throughput: one emit per cycle. A continuous in-order input stream yields continuous out_valid after 2 cycles of latency.
- Simultaneous write and drain:
  - Always allowed, since they target different slots; a write to the slot being drained is impossible (diff=0 means the slot was empty).
  - occupancy = occupancy + accepted - drained.
- No backpressure: downstream is always ready.
  - Full buffer is safe by construction: the window check bounds entries to DEPTH.
  - When occupancy=DEPTH, only records with diff < DEPTH can arrive, and they are duplicates.
- Errors are sticky until reset; the block keeps operating after an error.
- Gap: if next_order never arrives, the output stalls indefinitely; there is no timeout.

Test Plan:
- In-order stream: orders 0..15, one per cycle → out_valid continuous from the second cycle after the first input; out_order 0..15 in sequence; errors remain 0.
- Reversed window: orders 7,6,…,0 → nothing emitted until 0 is accepted; then 0..7 emitted on consecutive cycles; occupancy peaks at 8 and returns to 0.
- Wrap-around: force next_order to 254 via stream 0..253, then inputs 255,254,0,1 → emitted 254,255,0,1 in order.
- Duplicate/stale:
  - order 3 sent twice while buffered → err_dup=1; single emit of 3.
  - order 2 after 2 has been emitted → err_dup=1.
- Window violation: next_order=0, input order 8 (DEPTH=8) → err_window=1; record dropped; occupancy unchanged.
- Reset mid-operation: orders 1,2 buffered, then resetn pulsed low → all outputs 0 immediately; after release, order 0 is emitted alone and 1,2 are never emitted.
